// File: rtl/pcie_read_fifo.sv
// rtl/pcie_read_fifo.sv - host-to-card DMA reader: tagged 128-byte read requests, reordered FIFO output
module pcie_read_fifo #(
  parameter int TAGS_LOG2 = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_valid,
  input  logic [63:0] start_address,
  input  logic [23:0] start_blocks,
  output logic        read_request_valid,
  output logic [63:0] read_request_address,
  output logic [7:0]  read_request_tag,
  input  logic        read_request_ready,
  input  logic        completion_valid,
  input  logic [7:0]  completion_tag,
  input  logic [63:0] completion_data,
  output logic        fifo_valid,
  output logic [63:0] fifo_data,
  input  logic        fifo_ready,
  output logic        active,
  output logic [23:0] block_count,
  output logic        error
);
  localparam int         NSLOTS   = 1 << TAGS_LOG2;
  localparam logic [7:0] L_NSLOTS = 8'(NSLOTS);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;

  logic [0:0]           r_state;
  logic [63:0]          r_addr;
  logic [23:0]          r_remaining;
  logic [23:0]          r_total;
  logic [23:0]          r_block_count;
  logic [TAGS_LOG2-1:0] r_req_ptr;
  logic [TAGS_LOG2-1:0] r_head;
  logic [NSLOTS-1:0]    r_outstanding;
  logic [4:0]           r_count [NSLOTS];
  logic [4:0]           r_rd_idx;
  logic                 r_fifo_valid;
  logic [63:0]          r_fifo_data;
  logic                 r_error;
  logic [63:0]          r_mem [NSLOTS*16];

  logic                 w_start;
  logic [TAGS_LOG2-1:0] w_ctag;
  logic                 w_cmp_accept;
  logic                 w_cmp_error;
  logic                 w_req_valid;
  logic                 w_req_fire;
  logic                 w_head_complete;
  logic                 w_load;
  logic                 w_pop;
  logic                 w_last_pop;
  logic                 w_done;

  assign w_start         = (r_state == S_IDLE) && start_valid && (start_blocks != 24'd0);
  assign w_ctag          = completion_tag[TAGS_LOG2-1:0];
  assign w_cmp_accept    = completion_valid && (completion_tag < L_NSLOTS) &&
                           r_outstanding[w_ctag] && (r_count[w_ctag] < 5'd16);
  assign w_cmp_error     = completion_valid && !w_cmp_accept;
  assign w_req_valid     = (r_state == S_RUN) && (r_remaining != 24'd0) && !r_outstanding[r_req_ptr];
  assign w_req_fire      = w_req_valid && read_request_ready;
  assign w_head_complete = r_outstanding[r_head] && (r_count[r_head] == 5'd16);
  // r_rd_idx counts beats already loaded; at most one beat sits in the output register
  assign w_load          = w_head_complete && (r_rd_idx < 5'd16) && (!r_fifo_valid || fifo_ready);
  assign w_pop           = r_fifo_valid && fifo_ready;
  assign w_last_pop      = w_pop && (r_rd_idx == 5'd16);
  assign w_done          = w_last_pop && ((r_block_count + 24'd1) == r_total);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_addr        <= 64'd0;
      r_remaining   <= 24'd0;
      r_total       <= 24'd0;
      r_block_count <= 24'd0;
      r_req_ptr     <= '0;
      r_head        <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_start) begin
        r_state       <= S_RUN;
        r_addr        <= start_address & ~64'h7F;
        r_remaining   <= start_blocks;
        r_total       <= start_blocks;
        r_block_count <= 24'd0;
        r_req_ptr     <= '0;
        r_head        <= '0;
      end else begin
        if (w_req_fire) begin
          r_addr      <= r_addr + 64'd128;
          r_remaining <= r_remaining - 24'd1;
          r_req_ptr   <= r_req_ptr + 1'b1;
        end
        if (w_last_pop) begin
          r_head        <= r_head + 1'b1;
          r_block_count <= r_block_count + 24'd1;
        end
        if (w_done) r_state <= S_IDLE;
      end
      if (w_start)     r_error <= 1'b0;
      if (w_cmp_error) r_error <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      for (int i = 0; i < NSLOTS; i++) r_count[i] <= 5'd0;
    end else begin
      for (int i = 0; i < NSLOTS; i++) begin
        if (w_req_fire && (r_req_ptr == TAGS_LOG2'(i))) begin
          r_outstanding[i] <= 1'b1;
          r_count[i]       <= 5'd0;
        end else begin
          if (w_cmp_accept && (w_ctag == TAGS_LOG2'(i))) r_count[i] <= r_count[i] + 5'd1;
          if (w_last_pop && (r_head == TAGS_LOG2'(i)))   r_outstanding[i] <= 1'b0;
        end
      end
    end
  end

  // completions only ever land in slots that are not yet complete, so they never collide with the head read
  always_ff @(posedge clock) begin
    if (w_cmp_accept) r_mem[{w_ctag, r_count[w_ctag][3:0]}] <= completion_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fifo_valid <= 1'b0;
      r_fifo_data  <= 64'd0;
      r_rd_idx     <= 5'd0;
    end else begin
      if (w_load) begin
        r_fifo_data  <= r_mem[{r_head, r_rd_idx[3:0]}];
        r_fifo_valid <= 1'b1;
        r_rd_idx     <= r_rd_idx + 5'd1;
      end else if (w_pop) begin
        r_fifo_valid <= 1'b0;
      end
      if (w_last_pop) r_rd_idx <= 5'd0;
    end
  end

  assign read_request_valid   = w_req_valid;
  assign read_request_address = r_addr;
  assign read_request_tag     = 8'(r_req_ptr);
  assign fifo_valid           = r_fifo_valid;
  assign fifo_data            = r_fifo_data;
  assign active               = (r_state == S_RUN);
  assign block_count          = r_block_count;
  assign error                = r_error;

endmodule
